// File: rtl/twi_master_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// twi_master_sequencer_pkg
// Shared types and constants for the TWI master sequencer:
//   - state_t      : master-mode sequencer states
//   - phase_ctl_t  : bundle of the phase enables / direction selects
//   - ST_*         : TWS[7:3] status codes (TWSR = {code, 3'b000})
//   - decode_phase : maps a state (and master ownership) onto the phase bundle
// -----------------------------------------------------------------------------
package twi_master_sequencer_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_WAIT_BUS = 4'd1,
    S_START    = 4'd2,
    S_HOLD     = 4'd3,
    S_TX_BYTE  = 4'd4,
    S_ACK_RX   = 4'd5,
    S_RX_BYTE  = 4'd6,
    S_ACK_TX   = 4'd7,
    S_STOP     = 4'd8
  } state_t;

  localparam int STATUS_W = 5;

  // TWS[7:3] codes; the full TWSR value is the code shifted left by 3.
  localparam logic [STATUS_W-1:0] ST_START        = 5'h01;  // 0x08
  localparam logic [STATUS_W-1:0] ST_RESTART      = 5'h02;  // 0x10
  localparam logic [STATUS_W-1:0] ST_SLAW_ACK     = 5'h03;  // 0x18
  localparam logic [STATUS_W-1:0] ST_SLAW_NACK    = 5'h04;  // 0x20
  localparam logic [STATUS_W-1:0] ST_DATA_TX_ACK  = 5'h05;  // 0x28
  localparam logic [STATUS_W-1:0] ST_DATA_TX_NACK = 5'h06;  // 0x30
  localparam logic [STATUS_W-1:0] ST_ARB_LOST     = 5'h07;  // 0x38
  localparam logic [STATUS_W-1:0] ST_SLAR_ACK     = 5'h08;  // 0x40
  localparam logic [STATUS_W-1:0] ST_SLAR_NACK    = 5'h09;  // 0x48
  localparam logic [STATUS_W-1:0] ST_DATA_RX_ACK  = 5'h0A;  // 0x50
  localparam logic [STATUS_W-1:0] ST_DATA_RX_NACK = 5'h0B;  // 0x58
  localparam logic [STATUS_W-1:0] ST_NOINFO       = 5'h1F;  // 0xF8

  typedef struct packed {
    logic start_en;
    logic restart_en;
    logic stop_en;
    logic data_en;
    logic ack_en;
    logic data_dir;
    logic ack_dir;
  } phase_ctl_t;

  // Phase outputs are a pure function of the state; START splits into a
  // fresh start or a repeated start depending on whether we already own
  // the bus.
  function automatic phase_ctl_t decode_phase(input state_t s, input logic master_mode);
    phase_ctl_t c;
    c = '0;
    case (s)
      S_START: begin
        c.start_en   = ~master_mode;
        c.restart_en = master_mode;
      end
      S_TX_BYTE: begin
        c.data_en  = 1'b1;
        c.data_dir = 1'b1;
      end
      S_ACK_RX: c.ack_en = 1'b1;
      S_RX_BYTE: c.data_en = 1'b1;
      S_ACK_TX: begin
        c.ack_en  = 1'b1;
        c.ack_dir = 1'b1;
      end
      S_STOP: c.stop_en = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/twi_master_sequencer_status_encoder.sv
// -----------------------------------------------------------------------------
// twi_master_sequencer_status_encoder
// Combinational TWS[7:3] lookup: given the current sequencer state and the
// transaction flags, produce the status code that the sequencer loads when
// the event it is waiting for in that state occurs.
// Ports:
//   i_state            current sequencer state
//   i_master_mode      bus already owned (selects restart code in START)
//   i_sla_sent         address byte already done (address vs data phase)
//   i_rw_bit           SLA R/W bit (1 = read)
//   i_ack_bit          sampled ACK bit (0 = ACK)
//   i_arbitration_lost arbitration lost pulse
//   o_status           status code to load
// -----------------------------------------------------------------------------
module twi_master_sequencer_status_encoder
  import twi_master_sequencer_pkg::*;
(
  input  state_t              i_state,
  input  logic                i_master_mode,
  input  logic                i_sla_sent,
  input  logic                i_rw_bit,
  input  logic                i_ack_bit,
  input  logic                i_arbitration_lost,
  output logic [STATUS_W-1:0] o_status
);

  logic w_arb_state;

  // Arbitration can only be lost while we are driving the bus.
  assign w_arb_state = (i_state == S_START) || (i_state == S_TX_BYTE) ||
                       (i_state == S_ACK_RX);

  always_comb begin
    o_status = ST_NOINFO;
    if (i_arbitration_lost && w_arb_state) begin
      o_status = ST_ARB_LOST;
    end else begin
      case (i_state)
        S_START: o_status = i_master_mode ? ST_RESTART : ST_START;
        S_ACK_RX: begin
          if (!i_sla_sent) begin
            if (i_rw_bit) o_status = i_ack_bit ? ST_SLAR_NACK : ST_SLAR_ACK;
            else          o_status = i_ack_bit ? ST_SLAW_NACK : ST_SLAW_ACK;
          end else begin
            o_status = i_ack_bit ? ST_DATA_TX_NACK : ST_DATA_TX_ACK;
          end
        end
        S_ACK_TX: o_status = i_ack_bit ? ST_DATA_RX_NACK : ST_DATA_RX_ACK;
        default:  o_status = ST_NOINFO;
      endcase
    end
  end

endmodule

// File: rtl/twi_master_sequencer.sv
// -----------------------------------------------------------------------------
// twi_master_sequencer
// Master-mode control FSM between the TWI register file and the bus interface
// unit. Turns TWCR writes into START / address / data / ACK / STOP phases,
// consumes the unit's completion and arbitration flags, and produces TWINT,
// the master_mode qualifier and the TWS[7:3] status code.
// Ports:
//   i_clk, i_resetn              clock, async active-low reset
//   i_flop_en                    global update enable
//   i_twcr_wr_en                 TWCR write strobe
//   i_twen/i_twsta/i_twsto       TWCR write value bits
//   i_twint_clr                  TWCR.TWINT write value (1 clears TWINT)
//   i_rw_bit                     SLA R/W bit (1 = read)
//   i_bus_busy                   bus busy from detector
//   i_start_complete             start / restart generated
//   i_stop_complete              stop generated
//   i_arbitration_lost           arbitration lost pulse
//   i_byte_transfer_complete     8 bits shifted
//   i_ack_transfer_complete      ACK bit shifted
//   i_ack_bit                    sampled ACK (0 = ACK)
//   o_start_en/o_restart_en/o_stop_en   start/stop generator enables
//   o_data_transfer_en/o_ack_transfer_en phase enables
//   o_data_transfer_dir/o_ack_transfer_dir 1 = master drives SDA
//   o_twint                      interrupt flag / SCL stretch
//   o_sla_sent                   address byte done for this transaction
//   o_master_mode                master owns the bus
//   o_status                     TWS[7:3]
// -----------------------------------------------------------------------------
module twi_master_sequencer
  import twi_master_sequencer_pkg::*;
#(
  parameter int TWDR_WIDTH   = 8,
  parameter int STATUS_WIDTH = 5
) (
  input  logic                    i_clk,
  input  logic                    i_resetn,
  input  logic                    i_flop_en,
  input  logic                    i_twcr_wr_en,
  input  logic                    i_twen,
  input  logic                    i_twsta,
  input  logic                    i_twsto,
  input  logic                    i_twint_clr,
  input  logic                    i_rw_bit,
  input  logic                    i_bus_busy,
  input  logic                    i_start_complete,
  input  logic                    i_stop_complete,
  input  logic                    i_arbitration_lost,
  input  logic                    i_byte_transfer_complete,
  input  logic                    i_ack_transfer_complete,
  input  logic                    i_ack_bit,
  output logic                    o_start_en,
  output logic                    o_restart_en,
  output logic                    o_stop_en,
  output logic                    o_data_transfer_en,
  output logic                    o_ack_transfer_en,
  output logic                    o_data_transfer_dir,
  output logic                    o_ack_transfer_dir,
  output logic                    o_twint,
  output logic                    o_sla_sent,
  output logic                    o_master_mode,
  output logic [STATUS_WIDTH-1:0] o_status
);

  // The status codes are the fixed 8-bit TWSR encoding; other widths have
  // no meaning for this block.
  if (TWDR_WIDTH != 8 || STATUS_WIDTH != STATUS_W) begin : g_bad_params
    $error("twi_master_sequencer: TWDR_WIDTH must be 8 and STATUS_WIDTH must be 5");
  end

  state_t              r_state;
  phase_ctl_t          r_ctl;
  logic                r_twint;
  logic                r_sla_sent;
  logic                r_master_mode;
  logic                r_pend_start;
  logic [STATUS_W-1:0] r_status;

  logic                w_wr_accept;
  logic                w_hold_accept;
  logic [STATUS_W-1:0] w_status_evt;

  // Normal TWCR writes need TWINT written as 1; in HOLD a STOP request is
  // taken even without it so software can always release the bus.
  assign w_wr_accept   = i_twcr_wr_en && i_twint_clr;
  assign w_hold_accept = w_wr_accept || (i_twcr_wr_en && i_twsto);

  twi_master_sequencer_status_encoder u_status_enc (
    .i_state            (r_state),
    .i_master_mode      (r_master_mode),
    .i_sla_sent         (r_sla_sent),
    .i_rw_bit           (i_rw_bit),
    .i_ack_bit          (i_ack_bit),
    .i_arbitration_lost (i_arbitration_lost),
    .o_status           (w_status_evt)
  );

  // Single sequencer register block. Phase enables are registered alongside
  // every state change (decoded from the destination state) so they are
  // glitch-free and always match r_state.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state       <= S_IDLE;
      r_ctl         <= '0;
      r_twint       <= 1'b0;
      r_sla_sent    <= 1'b0;
      r_master_mode <= 1'b0;
      r_pend_start  <= 1'b0;
      r_status      <= ST_NOINFO;
    end else if (i_flop_en) begin
      if (i_twcr_wr_en && !i_twen) begin
        // Disabling the interface abandons whatever is in flight.
        r_state       <= S_IDLE;
        r_ctl         <= '0;
        r_twint       <= 1'b0;
        r_sla_sent    <= 1'b0;
        r_master_mode <= 1'b0;
        r_pend_start  <= 1'b0;
        r_status      <= ST_NOINFO;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_wr_accept) begin
              r_twint <= 1'b0;
              if (i_twsta) begin
                if (i_bus_busy) begin
                  r_state <= S_WAIT_BUS;
                  r_ctl   <= decode_phase(S_WAIT_BUS, r_master_mode);
                end else begin
                  r_state <= S_START;
                  r_ctl   <= decode_phase(S_START, r_master_mode);
                end
              end
            end
          end

          S_WAIT_BUS: begin
            if (!i_bus_busy) begin
              r_state <= S_START;
              r_ctl   <= decode_phase(S_START, r_master_mode);
            end
          end

          S_START: begin
            if (i_arbitration_lost) begin
              r_state       <= S_IDLE;
              r_ctl         <= decode_phase(S_IDLE, 1'b0);
              r_status      <= w_status_evt;
              r_twint       <= 1'b1;
              r_master_mode <= 1'b0;
              r_sla_sent    <= 1'b0;
            end else if (i_start_complete) begin
              r_state       <= S_HOLD;
              r_ctl         <= decode_phase(S_HOLD, 1'b1);
              r_status      <= w_status_evt;
              r_twint       <= 1'b1;
              r_master_mode <= 1'b1;
              r_sla_sent    <= 1'b0;
            end
          end

          S_HOLD: begin
            if (w_hold_accept) begin
              r_twint <= 1'b0;
              if (i_twsto) begin
                r_state      <= S_STOP;
                r_ctl        <= decode_phase(S_STOP, r_master_mode);
                r_pend_start <= i_twsta;
              end else if (i_twsta) begin
                r_state <= S_START;
                r_ctl   <= decode_phase(S_START, r_master_mode);
              end else if (!r_sla_sent || !i_rw_bit) begin
                r_state <= S_TX_BYTE;
                r_ctl   <= decode_phase(S_TX_BYTE, r_master_mode);
              end else begin
                r_state <= S_RX_BYTE;
                r_ctl   <= decode_phase(S_RX_BYTE, r_master_mode);
              end
            end
          end

          S_TX_BYTE: begin
            if (i_arbitration_lost) begin
              r_state       <= S_IDLE;
              r_ctl         <= decode_phase(S_IDLE, 1'b0);
              r_status      <= w_status_evt;
              r_twint       <= 1'b1;
              r_master_mode <= 1'b0;
              r_sla_sent    <= 1'b0;
            end else if (i_byte_transfer_complete) begin
              r_state <= S_ACK_RX;
              r_ctl   <= decode_phase(S_ACK_RX, r_master_mode);
            end
          end

          S_ACK_RX: begin
            if (i_arbitration_lost) begin
              r_state       <= S_IDLE;
              r_ctl         <= decode_phase(S_IDLE, 1'b0);
              r_status      <= w_status_evt;
              r_twint       <= 1'b1;
              r_master_mode <= 1'b0;
              r_sla_sent    <= 1'b0;
            end else if (i_ack_transfer_complete) begin
              r_state    <= S_HOLD;
              r_ctl      <= decode_phase(S_HOLD, r_master_mode);
              r_status   <= w_status_evt;
              r_twint    <= 1'b1;
              r_sla_sent <= 1'b1;
            end
          end

          S_RX_BYTE: begin
            if (i_byte_transfer_complete) begin
              r_state <= S_ACK_TX;
              r_ctl   <= decode_phase(S_ACK_TX, r_master_mode);
            end
          end

          S_ACK_TX: begin
            if (i_ack_transfer_complete) begin
              r_state  <= S_HOLD;
              r_ctl    <= decode_phase(S_HOLD, r_master_mode);
              r_status <= w_status_evt;
              r_twint  <= 1'b1;
            end
          end

          S_STOP: begin
            if (i_stop_complete) begin
              r_master_mode <= 1'b0;
              r_sla_sent    <= 1'b0;
              r_status      <= ST_NOINFO;
              r_twint       <= 1'b0;
              r_pend_start  <= 1'b0;
              if (r_pend_start) begin
                r_state <= S_START;
                r_ctl   <= decode_phase(S_START, 1'b0);
              end else begin
                r_state <= S_IDLE;
                r_ctl   <= decode_phase(S_IDLE, 1'b0);
              end
            end
          end

          default: begin
            r_state <= S_IDLE;
            r_ctl   <= '0;
          end
        endcase
      end
    end
  end

  assign o_start_en          = r_ctl.start_en;
  assign o_restart_en        = r_ctl.restart_en;
  assign o_stop_en           = r_ctl.stop_en;
  assign o_data_transfer_en  = r_ctl.data_en;
  assign o_ack_transfer_en   = r_ctl.ack_en;
  assign o_data_transfer_dir = r_ctl.data_dir;
  assign o_ack_transfer_dir  = r_ctl.ack_dir;
  assign o_twint             = r_twint;
  assign o_sla_sent          = r_sla_sent;
  assign o_master_mode       = r_master_mode;
  assign o_status            = r_status;

endmodule
